// File: rtl/mem_arb_pkg.sv
// Shared defaults and the index-width helper for the memory arbiter.
package mem_arb_pkg;
  localparam int DEF_NUM_PORTS = 2;
  localparam int DEF_MEM_W     = 32;
  localparam int DEF_MAX_OUTST = 4;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mem_arb_rsp_fifo.sv
// Response-order FIFO: records which port (and word lane) each granted
// transaction belongs to so responses can be routed back in order.
module mem_arb_rsp_fifo
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = DEF_MAX_OUTST
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = idx_w(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign full      = (count_r == (PTR_W + 1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign head      = mem_r[rd_ptr_r];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/mem_arbiter_np.sv
// N-port memory arbiter with in-order response routing and lane alignment.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module mem_arbiter_np
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int MEM_W     = DEF_MEM_W,
  parameter int MAX_OUTST = DEF_MAX_OUTST
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_PORTS-1:0]                 port_req_i,
  output logic [NUM_PORTS-1:0]                 port_gnt_o,
  input  logic [NUM_PORTS-1:0][31:0]           port_addr_i,
  input  logic [NUM_PORTS-1:0]                 port_we_i,
  input  logic [NUM_PORTS-1:0][MEM_W/8-1:0]    port_be_i,
  input  logic [NUM_PORTS-1:0][MEM_W-1:0]      port_wdata_i,
  output logic [NUM_PORTS-1:0]                 port_rvalid_o,
  output logic [NUM_PORTS-1:0][MEM_W-1:0]      port_rdata_o,
  output logic [NUM_PORTS-1:0]                 port_err_o,
  output logic                                 mem_req_o,
  output logic [31:0]                          mem_addr_o,
  output logic                                 mem_we_o,
  output logic [MEM_W/8-1:0]                   mem_be_o,
  output logic [MEM_W-1:0]                     mem_wdata_o,
  input  logic                                 mem_gnt_i,
  input  logic                                 mem_rvalid_i,
  input  logic                                 mem_err_i,
  input  logic [MEM_W-1:0]                     mem_rdata_i,
  output logic                                 spurious_rsp_o
);
  localparam int IDX_W = idx_w(NUM_PORTS);
  localparam int OFF_W = idx_w(MEM_W / 32);
  localparam int ENT_W = IDX_W + OFF_W;
  localparam int NWORD = MEM_W / 32;

  logic             any_req_s, full_s, empty_s, granted_s, rsp_s;
  logic [IDX_W-1:0] arb_s, win_s, head_idx_s, lock_idx_r;
  logic             lock_vld_r;
  logic [OFF_W-1:0] win_off_s, head_off_s;
  logic [ENT_W-1:0] head_s;
  logic [MEM_W-1:0] rdata_rot_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_r;
  logic             found_s;

  // Round-robin search beginning at the pointer.
  always_comb begin
    arb_s   = '0;
    found_s = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found_s && port_req_i[(int'(ptr_r) + i) % NUM_PORTS]) begin
        arb_s   = IDX_W'((int'(ptr_r) + i) % NUM_PORTS);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer advances past each granted port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_r <= '0;
    end else if (granted_s) begin
      ptr_r <= (int'(win_s) == NUM_PORTS - 1) ? '0 : win_s + 1'b1;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  // Fixed priority: lowest requesting index wins.
  always_comb begin
    arb_s = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      arb_s = port_req_i[i] ? IDX_W'(i) : arb_s;
    end
  end
`endif

  // A stalled winner keeps the bus until the downstream accepts it.
  assign win_s     = (lock_vld_r && port_req_i[lock_idx_r]) ? lock_idx_r : arb_s;
  assign any_req_s = |port_req_i;
  assign mem_req_o = any_req_s & ~full_s & ~rst_i;
  assign granted_s = mem_req_o & mem_gnt_i;
  assign rsp_s          = mem_rvalid_i & ~empty_s & ~rst_i;
  assign spurious_rsp_o = mem_rvalid_i & empty_s & ~rst_i;

  assign mem_addr_o  = port_addr_i[win_s];
  assign mem_we_o    = any_req_s & port_we_i[win_s];
  assign mem_be_o    = port_be_i[win_s];
  assign mem_wdata_o = port_wdata_i[win_s];

  generate
    if (MEM_W > 32) begin : g_off
      assign win_off_s = port_addr_i[win_s][OFF_W+1:2];
    end else begin : g_no_off
      assign win_off_s = '0;
    end
  endgenerate

  // Remember the stalled winner for the following cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_vld_r <= 1'b0;
      lock_idx_r <= '0;
    end else begin
      lock_vld_r <= mem_req_o & ~mem_gnt_i;
      lock_idx_r <= win_s;
    end
  end

  mem_arb_rsp_fifo #(.WIDTH(ENT_W), .DEPTH(MAX_OUTST)) u_rsp_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (granted_s),
    .push_data ({win_s, win_off_s}),
    .pop       (mem_rvalid_i & ~rst_i),
    .head      (head_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign {head_idx_s, head_off_s} = head_s;

  // Grant and response steering; all one-hot on the selected port.
  always_comb begin
    port_gnt_o    = '0;
    port_rvalid_o = '0;
    port_err_o    = '0;
    if (granted_s) begin
      port_gnt_o[win_s] = 1'b1;
    end else begin
      port_gnt_o = '0;
    end
    if (rsp_s) begin
      port_rvalid_o[head_idx_s] = 1'b1;
      port_err_o[head_idx_s]    = mem_err_i;
    end else begin
      port_rvalid_o = '0;
    end
  end

  // Rotate the addressed 32-bit word down into lane 0.
  always_comb begin
    rdata_rot_s = mem_rdata_i;
    for (int w = 0; w < NWORD; w++) begin
      rdata_rot_s[32*w +: 32] = mem_rdata_i[32*((w + int'(head_off_s)) % NWORD) +: 32];
    end
  end

  // Read data is broadcast; rvalid selects the consumer.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_rdata_o[p] = rdata_rot_s;
    end
  end
endmodule

// File: tb/tb_mem_arbiter_np.sv
// Self-checking bench for mem_arbiter_np (3 ports, 64-bit memory, 4 outstanding).
module tb_mem_arbiter_np;
  localparam int NP = 3;
  localparam int MW = 64;
  localparam int MO = 4;
  localparam int BW = MW / 8;
  localparam logic [63:0] RD = 64'hAAAA_BBBB_CCCC_DDDD;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0] port_req, port_gnt, port_we, port_rvalid, port_err;
  logic [NP-1:0][31:0]   port_addr;
  logic [NP-1:0][BW-1:0] port_be;
  logic [NP-1:0][MW-1:0] port_wdata, port_rdata;
  logic mem_req, mem_we, mem_gnt, mem_rvalid, mem_err, spurious;
  logic [31:0]   mem_addr;
  logic [BW-1:0] mem_be;
  logic [MW-1:0] mem_wdata, mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter_np #(.NUM_PORTS(NP), .MEM_W(MW), .MAX_OUTST(MO)) dut (
    .clk_i(clk), .rst_i(rst),
    .port_req_i(port_req), .port_gnt_o(port_gnt), .port_addr_i(port_addr),
    .port_we_i(port_we), .port_be_i(port_be), .port_wdata_i(port_wdata),
    .port_rvalid_o(port_rvalid), .port_rdata_o(port_rdata), .port_err_o(port_err),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_err_i(mem_err), .mem_rdata_i(mem_rdata), .spurious_rsp_o(spurious)
  );

  // Reference model: queue of outstanding {port, lane} plus arbitration state.
  typedef struct { int port; int off; } ent_t;
  ent_t q[$];
  int   rr_ptr = 0;
  int   lock_port = 0;
  bit   lock_vld = 1'b0;

  logic          e_mem_req, e_spur;
  logic [NP-1:0] e_gnt, e_rvalid, e_err;
  logic [MW-1:0] e_rdata;
  int            e_win;

  typedef struct {
    logic rst; logic [2:0] req; logic gnt, rv, er; logic [63:0] rd;
    logic x_req; logic [2:0] x_gnt, x_rv, x_err; logic x_spur;
    logic [31:0] x_addr, x_rlo;
  } vec_t;
  vec_t tbl[13];
  logic [2:0] seq[6];

  function automatic int pick(input logic [NP-1:0] req);
    if (lock_vld && req[lock_port]) return lock_port;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < NP; i++) if (req[(rr_ptr + i) % NP]) return (rr_ptr + i) % NP;
`else
    for (int i = 0; i < NP; i++) if (req[i]) return i;
`endif
    return 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle after the falling edge, compute expectations, advance the model.
  task automatic step(input logic r, input logic [NP-1:0] req, input logic g,
                      input logic rv, input logic er, input logic [MW-1:0] rd, input bit rnd);
    @(negedge clk);
    rst = r; port_req = req; mem_gnt = g; mem_rvalid = rv; mem_err = er; mem_rdata = rd;
    if (rnd) begin
      for (int i = 0; i < NP; i++) begin
        port_addr[i]  = $urandom;
        port_we[i]    = 1'($urandom);
        port_be[i]    = BW'($urandom);
        port_wdata[i] = {$urandom, $urandom};
      end
    end
    #1;
    e_win     = pick(req);
    e_mem_req = !r && (req != '0) && (q.size() < MO);
    e_gnt     = '0;
    if (e_mem_req && g) e_gnt[e_win] = 1'b1;
    e_rvalid = '0; e_err = '0; e_rdata = rd;
    e_spur   = !r && rv && (q.size() == 0);
    if (!r && rv && q.size() > 0) begin
      e_rvalid[q[0].port] = 1'b1;
      e_err[q[0].port]    = er;
      if (q[0].off != 0) e_rdata = {rd[31:0], rd[63:32]};
    end
    if (r) begin
      q.delete(); rr_ptr = 0; lock_vld = 1'b0;
    end else begin
      if (rv && q.size() > 0) void'(q.pop_front());
      if (e_gnt != '0) begin
        q.push_back('{e_win, int'(port_addr[e_win][2])});
        rr_ptr = (e_win + 1) % NP;
      end
      lock_vld  = e_mem_req && !g;
      lock_port = e_win;
    end
  endtask

  task automatic check_model();
    chk("mem_req", 64'(mem_req), 64'(e_mem_req));
    chk("gnt", 64'(port_gnt), 64'(e_gnt));
    chk("rvalid", 64'(port_rvalid), 64'(e_rvalid));
    chk("err", 64'(port_err), 64'(e_err));
    chk("spurious", 64'(spurious), 64'(e_spur));
    if (!rst) begin
      chk("mem_addr", 64'(mem_addr), 64'(port_addr[e_win]));
      chk("mem_we", 64'(mem_we), 64'((port_req != '0) & port_we[e_win]));
      if (port_req != '0) begin
        chk("mem_be", 64'(mem_be), 64'(port_be[e_win]));
        chk("mem_wdata", mem_wdata, port_wdata[e_win]);
      end
    end
    for (int p = 0; p < NP; p++) if (e_rvalid[p]) chk("rdata", port_rdata[p], e_rdata);
  endtask

  initial begin
    rst = 1'b1; port_req = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
    mem_rdata = '0; port_we = '0; port_be = '1;
    port_addr[0] = 32'h0000_1000; port_addr[1] = 32'h0000_0104; port_addr[2] = 32'h0000_2008;
    for (int i = 0; i < NP; i++) port_wdata[i] = {32'(i), 32'h5A5A_0000};

    //          rst   req     gnt   rv    er    rd      x_req x_gnt   x_rv    x_err   spur  x_addr        x_rlo
    tbl[0]  = '{1'b1, 3'b111, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 32'h0,        32'h0};
    tbl[1]  = '{1'b1, 3'b111, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 32'h0,        32'h0};
    tbl[2]  = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 32'h0,        32'h0};
    tbl[3]  = '{1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b1, 32'h0,        32'h0};
    tbl[4]  = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 32'h0,        32'h0};
    tbl[5]  = '{1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 3'b001, 3'b000, 3'b000, 1'b0, 32'h0000_1000, 32'h0};
    tbl[6]  = '{1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 32'h0000_0104, 32'h0};
    tbl[7]  = '{1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 32'h0000_0104, 32'h0};
    tbl[8]  = '{1'b0, 3'b011, 1'b1, 1'b1, 1'b0, RD,    1'b1, 3'b010, 3'b001, 3'b000, 1'b0, 32'h0000_0104, 32'hCCCC_DDDD};
    tbl[9]  = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b1, RD,    1'b0, 3'b000, 3'b010, 3'b010, 1'b0, 32'h0,        32'hAAAA_BBBB};
    tbl[10] = '{1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 32'h0,        32'h0};
    tbl[11] = '{1'b0, 3'b100, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 3'b100, 3'b000, 3'b000, 1'b0, 32'h0000_2008, 32'h0};
    tbl[12] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, RD,    1'b0, 3'b000, 3'b100, 3'b000, 1'b0, 32'h0,        32'hCCCC_DDDD};

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].er, tbl[i].rd, 1'b0);
      chk($sformatf("t%0d_mem_req", i), 64'(mem_req), 64'(tbl[i].x_req));
      chk($sformatf("t%0d_gnt", i), 64'(port_gnt), 64'(tbl[i].x_gnt));
      chk($sformatf("t%0d_rvalid", i), 64'(port_rvalid), 64'(tbl[i].x_rv));
      chk($sformatf("t%0d_err", i), 64'(port_err), 64'(tbl[i].x_err));
      chk($sformatf("t%0d_spurious", i), 64'(spurious), 64'(tbl[i].x_spur));
      if (tbl[i].x_req) chk($sformatf("t%0d_addr", i), 64'(mem_addr), 64'(tbl[i].x_addr));
      if (tbl[i].x_rv != 3'b000) chk($sformatf("t%0d_rdata", i), 64'(port_rdata[0][31:0]), 64'(tbl[i].x_rlo));
    end

    // Arbitration order with all ports requesting; one response per cycle keeps room.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
    seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
    step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 3'b111, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      chk($sformatf("arb%0d_gnt", i), 64'(port_gnt), 64'(seq[i]));
    end
    step(1'b0, 3'b110, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
    chk("arb_p0_drop_gnt", 64'(port_gnt), 64'(3'b010));

    // Outstanding limit: four grants, fifth held even while a response pops.
    step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
      chk($sformatf("full%0d_gnt", i), 64'(port_gnt), 64'(3'b001));
    end
    step(1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    chk("full_hold_req", 64'(mem_req), 64'(1'b0));
    chk("full_hold_gnt", 64'(port_gnt), 64'(3'b000));
    step(1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
    chk("full_pop_req", 64'(mem_req), 64'(1'b0));
    chk("full_pop_rvalid", 64'(port_rvalid), 64'(3'b001));
    step(1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    chk("full_resume_gnt", 64'(port_gnt), 64'(3'b001));

    // Reset with three in flight, then a fresh read on port 1 at 0x104.
    step(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    step(1'b1, 3'b010, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
    chk("rst_mem_req", 64'(mem_req), 64'(1'b0));
    chk("rst_gnt", 64'(port_gnt), 64'(3'b000));
    chk("rst_rvalid", 64'(port_rvalid), 64'(3'b000));
    step(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, RD, 1'b0);
    chk("post_rst_spurious", 64'(spurious), 64'(1'b1));
    chk("post_rst_rvalid", 64'(port_rvalid), 64'(3'b000));
    step(1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    chk("post_rst_gnt", 64'(port_gnt), 64'(3'b010));
    step(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, RD, 1'b0);
    chk("post_rst_rsp", 64'(port_rvalid), 64'(3'b010));
    chk("lane_rdata", 64'(port_rdata[1][31:0]), 64'(32'hAAAA_BBBB));

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 39) == 0), NP'($urandom), ($urandom_range(0, 9) < 7),
           1'($urandom), 1'($urandom), {$urandom, $urandom}, 1'b1);
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
